// File: rtl/dll_ctrl_pkg.sv
// Shared types and constants for the DLL lock controller.
package dll_ctrl_pkg;

  localparam int unsigned TAP_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RUN_W = 4;
  localparam int unsigned PH_W  = 2;

  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(255);

  // Slave phase encoding
  localparam logic [PH_W-1:0] PH_90  = 2'd0;
  localparam logic [PH_W-1:0] PH_180 = 2'd1;
  localparam logic [PH_W-1:0] PH_270 = 2'd2;
  localparam logic [PH_W-1:0] PH_360 = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    LOCKED = 3'd3,
    ERROR  = 3'd4
  } state_e;

  // Slave tap: (idx * (phase+1)) >> 2 from a 10-bit product, clamped to TAP_MAX.
  function automatic logic [TAP_W-1:0] slv_tap(input logic [TAP_W-1:0] idx,
                                               input logic [PH_W-1:0]  ph);
    logic [9:0] prod;
    logic [9:0] quot;
    prod = 10'(idx) * (10'(ph) + 10'd1);
    quot = 10'(prod >> 2);
    if (quot > 10'(TAP_MAX)) begin
      return TAP_MAX;
    end
    return quot[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/dll_pd_filter.sv
// Phase-detector synchronizer plus run-length filter producing tracking steps.
// The run-length counter is only built when DLL_TRACK_EN is defined.
module dll_pd_filter
  import dll_ctrl_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic smp_i,
  input  logic pd_early_i,
  output logic pd_s_o,
  output logic step_up_o,
  output logic step_dn_o
);

  logic pd_meta_q;
  logic pd_sync_q;

  // Two-flop synchronizer for the asynchronous detector output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pd_meta_q <= 1'b0;
      pd_sync_q <= 1'b0;
    end else begin
      pd_meta_q <= pd_early_i;
      pd_sync_q <= pd_meta_q;
    end
  end

  assign pd_s_o = pd_sync_q;

`ifdef DLL_TRACK_EN
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(FILT_LEN);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;

  // Count consecutive identical samples; a full run emits one step pulse
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    up_d   = 1'b0;
    dn_d   = 1'b0;
    if (clr_i) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (smp_i) begin
      if ((run_q == '0) || (pd_sync_q != last_q)) begin
        run_d = RUN_W'(1);
      end else begin
        run_d = run_q + RUN_W'(1);
      end
      last_d = pd_sync_q;
      if (run_d == RUN_TGT) begin
        run_d = '0;
        up_d  = pd_sync_q;
        dn_d  = ~pd_sync_q;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= '0;
      last_q <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
    end
  end

  assign step_up_o = up_q;
  assign step_dn_o = dn_q;
`else
  logic unused_trk;
  assign unused_trk = ^{clr_i, smp_i, RUN_W'(FILT_LEN)};
  assign step_up_o  = 1'b0;
  assign step_dn_o  = 1'b0;
`endif

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL calibration/lock controller: sweeps the master tap until the phase
// detector reports one period of delay, holds it, and derives the slave tap.
// Post-lock drift tracking is built only when DLL_TRACK_EN is defined.
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned MIN_SEL    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_pd_early,
  input  logic [PH_W-1:0]  i_phase,
  output logic [TAP_W-1:0] o_mst_sel,
  output logic [TAP_W-1:0] o_slv_sel,
  output logic             o_busy,
  output logic             o_locked,
  output logic             o_err
);

  localparam logic [TAP_W-1:0] MIN_TAP     = TAP_W'(MIN_SEL);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] slv_q, slv_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic pd_s;
  logic step_up;
  logic step_dn;
  logic trk_smp_c;
  logic trk_clr_c;

`ifdef DLL_TRACK_EN
  assign trk_smp_c = (state_q == LOCKED) && (cnt_q == SETTLE_LAST);
  assign trk_clr_c = (state_q != LOCKED) || !i_en;
`else
  logic unused_steps;
  assign unused_steps = step_up ^ step_dn;
  assign trk_smp_c    = 1'b0;
  assign trk_clr_c    = 1'b1;
`endif

  dll_pd_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_pd_filter (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .clr_i      (trk_clr_c),
    .smp_i      (trk_smp_c),
    .pd_early_i (i_pd_early),
    .pd_s_o     (pd_s),
    .step_up_o  (step_up),
    .step_dn_o  (step_dn)
  );

  // Next-state, tap index and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SETTLE;
          idx_d   = MIN_TAP;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        cnt_d = '0;
        if (!pd_s) begin
          state_d = LOCKED;
        end else if (idx_q != TAP_MAX) begin
          state_d = SETTLE;
          idx_d   = idx_q + TAP_W'(1);
        end else begin
          state_d = ERROR;
        end
      end
      LOCKED: begin
        if (i_start) begin
          state_d = SETTLE;
          idx_d   = MIN_TAP;
          cnt_d   = '0;
        end else begin
`ifdef DLL_TRACK_EN
          cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (step_up) begin
            if (idx_q == TAP_MAX) begin
              state_d = ERROR;
            end else begin
              idx_d = idx_q + TAP_W'(1);
            end
          end else if (step_dn && (idx_q > MIN_TAP)) begin
            idx_d = idx_q - TAP_W'(1);
          end
`endif
        end
      end
      ERROR: begin
        if (i_start) begin
          state_d = SETTLE;
          idx_d   = MIN_TAP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = MIN_TAP;
        cnt_d   = '0;
      end
    endcase

    // Enable low overrides everything, including a start request
    if (!i_en) begin
      state_d = IDLE;
      idx_d   = MIN_TAP;
      cnt_d   = '0;
    end

    busy_d   = (state_d == SETTLE) || (state_d == SAMPLE);
    locked_d = (state_d == LOCKED);
    err_d    = (state_d == ERROR);
    slv_d    = (locked_d || err_d) ? slv_tap(idx_d, i_phase) : '0;
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= MIN_TAP;
      cnt_q    <= '0;
      slv_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      slv_q    <= slv_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign o_mst_sel = idx_q;
  assign o_slv_sel = slv_q;
  assign o_busy    = busy_q;
  assign o_locked  = locked_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Self-checking bench for dll_lock_ctrl against a behavioural DLL model.
module tb_dll_lock_ctrl;

  localparam int SC  = 8;
  localparam int FL  = 4;
  localparam int MS  = 1;
  localparam int MAXTAP = 255;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       pd_early;
  logic [1:0] phase;
  logic [7:0] mst_sel;
  logic [7:0] slv_sel;
  logic       busy;
  logic       locked;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  // Delay-line model: detector reports early while the tap is below tgt
  int tgt     = 40;
  bit pd_auto = 1'b1;

  dll_lock_ctrl #(
    .SETTLE_CYC (SC),
    .FILT_LEN   (FL),
    .MIN_SEL    (MS)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_start    (start),
    .i_pd_early (pd_early),
    .i_phase    (phase),
    .o_mst_sel  (mst_sel),
    .o_slv_sel  (slv_sel),
    .o_busy     (busy),
    .o_locked   (locked),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pd_early = 1'b0;
    forever begin
      @(negedge clk);
      if (pd_auto) pd_early = (int'(mst_sel) < tgt);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_slv(input int tap, input int ph);
    int v;
    v = (tap * (ph + 1)) / 4;
    return (v > MAXTAP) ? MAXTAP : v;
  endfunction

  // Expected final tap for a target; >MAXTAP means the sweep runs out
  function automatic int model_tap(input int t);
    if (t <= MS) return MS;
    if (t > MAXTAP) return MAXTAP;
    return t;
  endfunction

  // Pulse start, then count cycles with busy high (optionally a stray start)
  task automatic run_cal(input int t, input int inj, output int nbusy);
    tgt = t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 4000) begin
      nbusy++;
      if (nbusy == inj) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk("sweep_done", int'(busy), 0);
  endtask

  task automatic check_result(input string tag, input int t, input int nbusy);
    int et;
    int eb;
    bit fail_sweep;
    et = model_tap(t);
    fail_sweep = (t > MAXTAP);
    eb = (et - MS + 1) * (SC + 1);
    chk({tag, "_mst"}, int'(mst_sel), et);
    chk({tag, "_locked"}, int'(locked), fail_sweep ? 0 : 1);
    chk({tag, "_err"}, int'(err), fail_sweep ? 1 : 0);
    chk({tag, "_slv"}, int'(slv_sel), model_slv(et, int'(phase)));
    chk({tag, "_busy_len_ok"}, int'((nbusy >= eb - 2) && (nbusy <= eb + 2)), 1);
  endtask

  initial begin
    int nb;
    int w;
    rst_n = 1'b0;
    en    = 1'b0;
    start = 1'b0;
    phase = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_mst", int'(mst_sel), MS);
    chk("rst_slv", int'(slv_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // Basic lock at tap 40, 90 degrees
    run_cal(40, 0, nb);
    check_result("lock40", 40, nb);

    // Detector stuck early: sweep runs out at 255
    phase = 2'd1;
    run_cal(256, 0, nb);
    check_result("stuck", 256, nb);

    // Restart from error clears it and reloads the first tap
    tgt = 30;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err", int'(err), 0);
    chk("restart_mst", int'(mst_sel), MS);
    chk("restart_busy", int'(busy), 1);
    w = 0;
    while (busy && w < 4000) begin
      w++;
      @(negedge clk);
    end
    chk("relock30_mst", int'(mst_sel), 30);
    chk("relock30_locked", int'(locked), 1);

    // Phase change with lock at 200
    phase = 2'd0;
    run_cal(200, 0, nb);
    check_result("lock200", 200, nb);
    phase = 2'd3;
    @(negedge clk);
    chk("ph360_slv", int'(slv_sel), 200);

    // Saturated slave tap at 255 / 360 degrees
    run_cal(256, 0, nb);
    chk("sat_slv", int'(slv_sel), 255);
    chk("sat_err", int'(err), 1);

    // Enable dropped mid-sweep at tap 17
    phase = 2'd2;
    tgt   = 120;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (mst_sel != 8'd17 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    chk("en_reach17", int'(mst_sel), 17);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_mst", int'(mst_sel), MS);
    chk("endrop_slv", int'(slv_sel), 0);
    chk("endrop_busy", int'(busy), 0);
    chk("endrop_locked", int'(locked), 0);
    chk("endrop_err", int'(err), 0);
    // Start while disabled must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("en_prio_busy", int'(busy), 0);
    en = 1'b1;

    // Asynchronous reset in the middle of a settle window
    tgt = 100;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (mst_sel != 8'd5 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    chk("arst_reach5", int'(mst_sel), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mst", int'(mst_sel), MS);
    chk("arst_busy", int'(busy), 0);
    chk("arst_locked", int'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle_busy", int'(busy), 0);

    // Randomized calibrations, some with a stray start mid-sweep
    for (int i = 0; i < 8; i++) begin
      int t;
      int inj;
      t     = int'($urandom_range(0, 262));
      phase = 2'($urandom_range(0, 3));
      inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0;
      run_cal(t, inj, nb);
      check_result("rand", t, nb);
    end

    // Post-lock behaviour at tap 100
    phase = 2'd0;
    run_cal(100, 0, nb);
    check_result("lock100", 100, nb);
    pd_auto = 1'b0;
`ifdef DLL_TRACK_EN
    pd_early = 1'b1;
    repeat (50) @(negedge clk);
    chk("trk_up_mst", int'(mst_sel), 101);
    chk("trk_up_slv", int'(slv_sel), model_slv(101, 0));
    pd_early = 1'b0;
    repeat (50) @(negedge clk);
    chk("trk_dn_mst", int'(mst_sel), 100);
    chk("trk_locked", int'(locked), 1);
`else
    for (int i = 0; i < 1000; i++) begin
      pd_early = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("frozen_mst", int'(mst_sel), 100);
    chk("frozen_locked", int'(locked), 1);
    chk("frozen_slv", int'(slv_sel), 25);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dll_lock_ctrl.md
Name: dll_lock_ctrl

Overview:
- Calibration and lock controller for the 256-tap DLL delay lines in the eMMC/AHB PHY path.
- Sweeps the master line's 8-bit tap select until the phase detector shows one reference period of delay, then holds that tap and reports lock.
- Derives a slave-line tap for a programmable quarter-period phase shift (sample-clock placement).
- Optionally keeps tracking voltage/temperature drift after lock.

Parameters:
- SETTLE_CYC, 8, cycles waited after every tap change before the phase detector is sampled (range 2..255).
- FILT_LEN, 4, consecutive identical filtered phase-detector samples needed for a tracking step (range 1..15).
- MIN_SEL, 1, first and lowest tap index used (range 1..254).

Ports:
- i_clk  input  1  controller clock; same clock feeds the master delay line.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  controller enable; low forces IDLE.
- i_start  input  1  single-cycle calibration request.
- i_pd_early  input  1  raw phase-detector output, asynchronous; 1 = delayed clock edge is early (delay too short).
- i_phase  input  2  slave phase: 0=90, 1=180, 2=270, 3=360 degrees.
- o_mst_sel  output  8  tap select to the master delay line.
- o_slv_sel  output  8  tap select to the slave delay line.
- o_busy  output  1  sweep in progress.
- o_locked  output  1  lock achieved and held.
- o_err  output  1  no lock found, or tracking saturated.

Behaviour:
- Reset values: o_mst_sel=MIN_SEL, o_slv_sel=0, o_busy=0, o_locked=0, o_err=0, FSM=IDLE.
- Phase-detector input: i_pd_early passes a 2-flop synchronizer; the synchronized value is pd_s.
- FSM states:
  - IDLE -> SETTLE when i_en=1 and i_start=1. Entry loads idx=MIN_SEL and sets o_busy=1.
  - SETTLE: counts SETTLE_CYC cycles, then goes to SAMPLE.
  - SAMPLE (one cycle):
    - pd_s=0: go to LOCKED with idx unchanged; o_busy=0, o_locked=1.
    - pd_s=1 and idx<255: idx+1, back to SETTLE.
    - pd_s=1 and idx=255: go to ERROR; o_busy=0, o_err=1, idx held at 255.
  - LOCKED: see tracking below.
  - ERROR: o_err stays high.
- Restart: i_start in LOCKED or ERROR clears o_locked and o_err, reloads MIN_SEL and re-enters SETTLE on the next cycle. i_start during SETTLE/SAMPLE is ignored.
- i_en=0 in any state: next cycle FSM=IDLE and all outputs return to reset values. i_en has priority over i_start.
- o_mst_sel = idx, registered; it changes 1 cycle after the FSM decision.
- o_slv_sel = ((idx * (i_phase+1)) >> 2), using a 10-bit product; bits [9:2] taken, saturated to 255. Registered with 1-cycle latency from idx or i_phase. Value is 0 whenever o_locked=0 and FSM is not in ERROR.
- Asynchronous reset mid-sweep: immediate return to reset values. No partial state survives.

Optional Feature:
- Macro: DLL_TRACK_EN.
- Defined: in LOCKED, pd_s is sampled every SETTLE_CYC cycles.
  - FILT_LEN consecutive samples of 1 -> idx+1.
  - FILT_LEN consecutive samples of 0 -> idx-1 when idx>MIN_SEL.
  - A change of sample value restarts the run count.
  - Early run at idx=255 -> ERROR (o_locked=0, o_err=1).
  - Late run at idx=MIN_SEL -> idx held, no error.
- Not defined: LOCKED holds idx frozen, pd_s is ignored and the filter logic is absent.

Decomposition:
- Package dll_ctrl_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, LOCKED, ERROR};
  - constant TAP_MAX=255;
  - TAP_W=8;
  - phase encoding constants.
- One natural sub-module, dll_pd_filter: synchronizer plus run-length counter. Outputs pd_s, step_up and step_dn pulses. Instantiated in all builds; the run counter is compiled only with DLL_TRACK_EN.

Test Plan:
- Model lock at tap 40, i_phase=0, start pulse:
  - pd_early=1 for idx<40.
  - Lock at o_mst_sel=40, o_slv_sel=10, o_locked=1.
  - o_busy high for exactly (40-1+1)*(SETTLE_CYC+1) cycles ±2.
- pd_early stuck at 1 -> o_mst_sel reaches 255, o_err=1, o_locked=0, o_busy=0; a later start pulse clears o_err and restarts at idx=1.
- Locked at 200, i_phase changes 0->3 -> o_slv_sel 50->200 one cycle later. At idx=255 with i_phase=3, o_slv_sel=255 (saturated).
- i_en dropped at idx=17 mid-sweep -> next cycle all outputs at reset values. Also: async reset asserted mid-SETTLE -> immediate reset values.
- DLL_TRACK_EN, locked at 100, FILT_LEN=4:
  - Samples 1,1,1,0,1,1,1,1 -> single increment to 101 after the 8th sample.
  - Four 0 samples -> back to 100.
- Without DLL_TRACK_EN, locked at 100 with pd toggling for 1000 cycles -> o_mst_sel stays 100.
